// File: rtl/tis_axil_rw_arbiter.sv
// Two-requester AXI4-Lite master sequencer for the tis100 S00_AXI register port.
// Define TIS_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties).
module tis_axil_rw_arbiter #(
   parameter int C_M_AXI_DATA_WIDTH = 32,
   parameter int C_M_AXI_ADDR_WIDTH = 6
) (
   input  logic                              M_AXI_ACLK,
   input  logic                              M_AXI_ARESETN,
   input  logic [1:0]                        req_valid,
   output logic [1:0]                        req_ready,
   input  logic [1:0]                        req_we,
   input  logic [2*C_M_AXI_ADDR_WIDTH-1:0]   req_addr,
   input  logic [2*C_M_AXI_DATA_WIDTH-1:0]   req_wdata,
   output logic [1:0]                        rsp_valid,
   output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
   output logic [1:0]                        rsp_resp,
   output logic                              busy,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
   output logic [2:0]                        M_AXI_AWPROT,
   output logic                              M_AXI_AWVALID,
   input  logic                              M_AXI_AWREADY,
   output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
   output logic                              M_AXI_WVALID,
   input  logic                              M_AXI_WREADY,
   input  logic [1:0]                        M_AXI_BRESP,
   input  logic                              M_AXI_BVALID,
   output logic                              M_AXI_BREADY,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
   output logic [2:0]                        M_AXI_ARPROT,
   output logic                              M_AXI_ARVALID,
   input  logic                              M_AXI_ARREADY,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
   input  logic [1:0]                        M_AXI_RRESP,
   input  logic                              M_AXI_RVALID,
   output logic                              M_AXI_RREADY
);

   typedef enum logic [2:0] {
      IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP
   } state_t;

   state_t                          state_q, state_d;
   logic                            id_q, id_d;
   logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [C_M_AXI_DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic [1:0]                      resp_q, resp_d;
   logic                            aw_done_q, aw_done_d;
   logic                            w_done_q, w_done_d;
   logic [1:0]                      gnt;
   logic                            win;
   logic                            aw_fin;
   logic                            w_fin;

`ifdef TIS_ARB_FIXED_PRIO_EN
   assign gnt[0] = req_valid[0];
`else
   logic last_q, last_d;

   // last_q names the requester served most recently; a tie goes to the other one
   assign last_d = (state_q == RSP) ? id_q : last_q;

   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
      if (!M_AXI_ARESETN) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

   assign gnt[0] = req_valid[0] & (~req_valid[1] | last_q);
`endif

   assign gnt[1] = req_valid[1] & ~gnt[0];
   assign win    = gnt[1];

   assign aw_fin = aw_done_q | (M_AXI_AWVALID & M_AXI_AWREADY);
   assign w_fin  = w_done_q  | (M_AXI_WVALID  & M_AXI_WREADY);

   always_comb begin
      state_d   = state_q;
      id_d      = id_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      resp_d    = resp_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      req_ready = 2'b00;
      unique case (state_q)
         IDLE: begin
            if (M_AXI_ARESETN && (gnt != 2'b00)) begin
               req_ready = gnt;
               id_d      = win;
               addr_d    = win ? req_addr[2*C_M_AXI_ADDR_WIDTH-1:C_M_AXI_ADDR_WIDTH]
                               : req_addr[C_M_AXI_ADDR_WIDTH-1:0];
               wdata_d   = win ? req_wdata[2*C_M_AXI_DATA_WIDTH-1:C_M_AXI_DATA_WIDTH]
                               : req_wdata[C_M_AXI_DATA_WIDTH-1:0];
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = req_we[win] ? WR_AW_W : RD_AR;
            end
         end
         WR_AW_W: begin
            aw_done_d = aw_fin;
            w_done_d  = w_fin;
            if (aw_fin && w_fin) begin
               state_d = WR_B;
            end
         end
         WR_B: begin
            if (M_AXI_BVALID) begin
               resp_d  = M_AXI_BRESP;
               rdata_d = '0;
               state_d = RSP;
            end
         end
         RD_AR: begin
            if (M_AXI_ARREADY) begin
               state_d = RD_R;
            end
         end
         RD_R: begin
            if (M_AXI_RVALID) begin
               rdata_d = M_AXI_RDATA;
               resp_d  = M_AXI_RRESP;
               state_d = RSP;
            end
         end
         RSP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
      if (!M_AXI_ARESETN) begin
         state_q   <= IDLE;
         id_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         resp_q    <= 2'b00;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         id_q      <= id_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         resp_q    <= resp_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end

   assign M_AXI_AWADDR  = addr_q;
   assign M_AXI_ARADDR  = addr_q;
   assign M_AXI_WDATA   = wdata_q;
   assign M_AXI_AWPROT  = 3'b000;
   assign M_AXI_ARPROT  = 3'b000;
   assign M_AXI_WSTRB   = '1;
   assign M_AXI_AWVALID = (state_q == WR_AW_W) & ~aw_done_q;
   assign M_AXI_WVALID  = (state_q == WR_AW_W) & ~w_done_q;
   assign M_AXI_BREADY  = (state_q == WR_B);
   assign M_AXI_ARVALID = (state_q == RD_AR);
   assign M_AXI_RREADY  = (state_q == RD_R);

   assign rsp_valid = (state_q != RSP) ? 2'b00 : (id_q ? 2'b10 : 2'b01);
   assign rsp_rdata = rdata_q;
   assign rsp_resp  = resp_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_tis_axil_rw_arbiter.sv
// Directed bench for tis_axil_rw_arbiter with a wait-state AXI4-Lite slave model.
// Expected responses are queued at acceptance and checked when rsp_valid pulses.
module tb_tis_axil_rw_arbiter;

   localparam int DW = 32;
   localparam int AW = 6;

   logic            clk = 1'b1;
   logic            rst_n = 1'b0;
   logic [1:0]      req_valid = 2'b00;
   logic [1:0]      req_ready;
   logic [1:0]      req_we = 2'b00;
   logic [2*AW-1:0] req_addr = '0;
   logic [2*DW-1:0] req_wdata = '0;
   logic [1:0]      rsp_valid;
   logic [DW-1:0]   rsp_rdata;
   logic [1:0]      rsp_resp;
   logic            busy;
   logic [AW-1:0]   awaddr, araddr;
   logic [2:0]      awprot, arprot;
   logic            awvalid, awready, wvalid, wready;
   logic [DW-1:0]   wdata, rdata;
   logic [3:0]      wstrb;
   logic [1:0]      bresp, rresp;
   logic            bvalid, bready, arvalid, arready, rvalid, rready;

   always #5 clk = ~clk;

   tis_axil_rw_arbiter dut (
      .M_AXI_ACLK    (clk),
      .M_AXI_ARESETN (rst_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_we        (req_we),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .rsp_valid     (rsp_valid),
      .rsp_rdata     (rsp_rdata),
      .rsp_resp      (rsp_resp),
      .busy          (busy),
      .M_AXI_AWADDR  (awaddr),
      .M_AXI_AWPROT  (awprot),
      .M_AXI_AWVALID (awvalid),
      .M_AXI_AWREADY (awready),
      .M_AXI_WDATA   (wdata),
      .M_AXI_WSTRB   (wstrb),
      .M_AXI_WVALID  (wvalid),
      .M_AXI_WREADY  (wready),
      .M_AXI_BRESP   (bresp),
      .M_AXI_BVALID  (bvalid),
      .M_AXI_BREADY  (bready),
      .M_AXI_ARADDR  (araddr),
      .M_AXI_ARPROT  (arprot),
      .M_AXI_ARVALID (arvalid),
      .M_AXI_ARREADY (arready),
      .M_AXI_RDATA   (rdata),
      .M_AXI_RRESP   (rresp),
      .M_AXI_RVALID  (rvalid),
      .M_AXI_RREADY  (rready)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // slave model with per-channel wait counts
   int          cfg_aw_wait = 0, cfg_w_wait = 0, cfg_ar_wait = 0, cfg_r_wait = 0;
   logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
   logic [31:0] cfg_rdata = 32'h0;
   int          s_aw_cnt, s_w_cnt, s_ar_cnt, s_r_cnt;
   logic        s_aw_got, s_w_got, s_rpend;

   assign awready = awvalid && (s_aw_cnt == cfg_aw_wait);
   assign wready  = wvalid && (s_w_cnt == cfg_w_wait);
   assign bvalid  = s_aw_got && s_w_got;
   assign bresp   = cfg_bresp;
   assign arready = arvalid && (s_ar_cnt == cfg_ar_wait);
   assign rvalid  = s_rpend && (s_r_cnt == cfg_r_wait);
   assign rdata   = rvalid ? cfg_rdata : 32'h0;
   assign rresp   = cfg_rresp;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_aw_cnt <= 0; s_w_cnt <= 0; s_ar_cnt <= 0; s_r_cnt <= 0;
         s_aw_got <= 1'b0; s_w_got <= 1'b0; s_rpend <= 1'b0;
      end else begin
         if (bvalid && bready) begin
            s_aw_got <= 1'b0;
            s_w_got  <= 1'b0;
         end
         if (awvalid && awready) begin
            s_aw_cnt <= 0; s_aw_got <= 1'b1;
         end else if (awvalid) s_aw_cnt <= s_aw_cnt + 1;
         if (wvalid && wready) begin
            s_w_cnt <= 0; s_w_got <= 1'b1;
         end else if (wvalid) s_w_cnt <= s_w_cnt + 1;
         if (arvalid && arready) begin
            s_ar_cnt <= 0; s_rpend <= 1'b1;
         end else if (arvalid) s_ar_cnt <= s_ar_cnt + 1;
         if (rvalid && rready) begin
            s_rpend <= 1'b0; s_r_cnt <= 0;
         end else if (s_rpend && !rvalid) s_r_cnt <= s_r_cnt + 1;
      end
   end

   // bus monitor
   int          aw_hs = 0, w_hs = 0, ar_hs = 0, ar_stall = 0, r_stall = 0;
   int          bready_early = 0, rw_overlap = 0, rsp_pulses = 0;
   logic [5:0]  aw_addr_last = '0, ar_addr_last = '0;
   logic [31:0] w_data_last = '0;

   always @(posedge clk) begin
      if (rsp_valid != 2'b00) rsp_pulses <= rsp_pulses + 1;
      if (rst_n) begin
         if (awvalid && awready) begin
            aw_hs <= aw_hs + 1; aw_addr_last <= awaddr;
         end
         if (wvalid && wready) begin
            w_hs <= w_hs + 1; w_data_last <= wdata;
         end
         if (arvalid && arready) begin
            ar_hs <= ar_hs + 1; ar_addr_last <= araddr;
         end
         if (arvalid && !arready) ar_stall <= ar_stall + 1;
         if (rready && !rvalid) r_stall <= r_stall + 1;
         if (bready && !(s_aw_got && s_w_got)) bready_early <= bready_early + 1;
         if ((awvalid || wvalid || bready) && (arvalid || rready))
            rw_overlap <= rw_overlap + 1;
      end
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   typedef struct {
      int          id;
      logic [31:0] rd;
      logic [1:0]  rs;
      int          c;
   } sb_t;

   sb_t sb[$];
   int  glog[$];
   int  gcyc[$];

   task automatic align();
      @(posedge clk);
      #1;
   endtask

   // drives the requests already set up, queues expectations, checks responses
   task automatic run(input int limit, input logic [1:0] hold, input int lat, input int budget);
      int          acc_n;
      int          k;
      int          id;
      logic [1:0]  acc;
      logic [1:0]  exp_v;
      sb_t         e;
      acc_n = 0;
      k = 0;
      while ((acc_n < limit || sb.size() != 0) && k < budget) begin
         @(negedge clk);
         k++;
         acc = req_valid & req_ready;
         if (rsp_valid != 2'b00) begin
            if (sb.size() == 0) begin
               check("rsp_unexpected", {62'b0, rsp_valid}, 64'd0);
            end else begin
               e = sb.pop_front();
               exp_v = (e.id == 1) ? 2'b10 : 2'b01;
               check("rsp_id", {62'b0, rsp_valid}, {62'b0, exp_v});
               check("rsp_rdata", {32'b0, rsp_rdata}, {32'b0, e.rd});
               check("rsp_resp", {62'b0, rsp_resp}, {62'b0, e.rs});
               check("busy_at_rsp", {63'b0, busy}, 64'd1);
               if (lat >= 0) check("rsp_latency", 64'(cyc - e.c), 64'(lat));
            end
         end
         id = acc[1] ? 1 : 0;
         if (acc != 2'b00) begin
            e.id = id;
            e.rd = req_we[id] ? 32'h0 : cfg_rdata;
            e.rs = req_we[id] ? cfg_bresp : cfg_rresp;
            e.c  = cyc;
            sb.push_back(e);
            glog.push_back(id);
            gcyc.push_back(cyc);
            acc_n++;
         end
         @(posedge clk);
         #1;
         if (acc != 2'b00) begin
            if (!hold[id]) req_valid[id] = 1'b0;
            if (acc_n >= limit) req_valid = 2'b00;
         end
      end
      check("run_in_budget", {63'b0, (k < budget)}, 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int exp_g[4];
   int p0, a0, w0, r0, as0, rs0;

   initial begin
`ifdef TIS_ARB_FIXED_PRIO_EN
      exp_g = '{0, 0, 0, 0};
`else
      exp_g = '{0, 1, 0, 1};
`endif
      // reset with a write pending on requester 0
      req_valid = 2'b01;
      req_we = 2'b01;
      req_addr[5:0] = 6'h00;
      req_wdata[31:0] = 32'd5;
      #12;
      check("rst_awvalid", {63'b0, awvalid}, 64'd0);
      check("rst_wvalid", {63'b0, wvalid}, 64'd0);
      check("rst_arvalid", {63'b0, arvalid}, 64'd0);
      check("rst_req_ready", {62'b0, req_ready}, 64'd0);
      check("rst_busy", {63'b0, busy}, 64'd0);
      check("rst_rsp_valid", {62'b0, rsp_valid}, 64'd0);
      #11;
      rst_n = 1'b1;
      run(1, 2'b00, 3, 20);
      check("t1_aw_hs", 64'(aw_hs), 64'd1);
      check("t1_w_hs", 64'(w_hs), 64'd1);
      check("t1_awaddr", {58'b0, aw_addr_last}, 64'h0);
      check("t1_wdata", {32'b0, w_data_last}, 64'd5);

      // requester 1 read with wait states on AR and R
      cfg_ar_wait = 3;
      cfg_r_wait = 2;
      cfg_rdata = 32'hDEAD_BEEF;
      as0 = ar_stall; rs0 = r_stall; r0 = ar_hs;
      req_we = 2'b00;
      req_addr[11:6] = 6'h04;
      req_valid = 2'b10;
      run(1, 2'b00, -1, 30);
      check("t2_ar_stall", 64'(ar_stall - as0), 64'd3);
      check("t2_r_stall", 64'(r_stall - rs0), 64'd2);
      check("t2_ar_hs", 64'(ar_hs - r0), 64'd1);
      check("t2_araddr", {58'b0, ar_addr_last}, 64'h04);

      // both requesters continuously valid
      cfg_ar_wait = 0;
      cfg_r_wait = 0;
      cfg_rdata = 32'h1234_5678;
      glog.delete();
      gcyc.delete();
      req_we = 2'b01;
      req_addr = {6'h08, 6'h0C};
      req_wdata = {32'h0, 32'hCAFE_0001};
      req_valid = 2'b11;
      run(4, 2'b11, 3, 60);
      check("t3_grants", 64'(glog.size()), 64'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < glog.size()) check($sformatf("t3_grant%0d", i), 64'(glog[i]), 64'(exp_g[i]));
      end
      if (gcyc.size() >= 2) check("t3_spacing", 64'(gcyc[1] - gcyc[0]), 64'd4);

      // WREADY ahead of AWREADY, then AWREADY ahead of WREADY
      cfg_aw_wait = 2;
      cfg_w_wait = 0;
      a0 = aw_hs; w0 = w_hs;
      req_we = 2'b01;
      req_addr[5:0] = 6'h10;
      req_wdata[31:0] = 32'hA5A5_A5A5;
      req_valid = 2'b01;
      run(1, 2'b00, -1, 30);
      check("t4a_aw_hs", 64'(aw_hs - a0), 64'd1);
      check("t4a_w_hs", 64'(w_hs - w0), 64'd1);
      check("t4a_awaddr", {58'b0, aw_addr_last}, 64'h10);
      check("t4a_wdata", {32'b0, w_data_last}, 64'hA5A5_A5A5);
      cfg_aw_wait = 0;
      cfg_w_wait = 2;
      a0 = aw_hs; w0 = w_hs;
      req_addr[5:0] = 6'h14;
      req_wdata[31:0] = 32'h5A5A_5A5A;
      req_valid = 2'b01;
      run(1, 2'b00, -1, 30);
      check("t4b_aw_hs", 64'(aw_hs - a0), 64'd1);
      check("t4b_w_hs", 64'(w_hs - w0), 64'd1);
      check("t4b_wdata", {32'b0, w_data_last}, 64'h5A5A_5A5A);
      check("t4_bready_early", 64'(bready_early), 64'd0);

      // slave error passed through
      cfg_w_wait = 0;
      cfg_bresp = 2'b10;
      req_we = 2'b10;
      req_addr[11:6] = 6'h20;
      req_wdata[63:32] = 32'h0000_0077;
      req_valid = 2'b10;
      run(1, 2'b00, 3, 20);
      @(negedge clk);
      check("t5_idle_busy", {63'b0, busy}, 64'd0);
      check("t5_idle_rsp", {62'b0, rsp_valid}, 64'd0);
      cfg_bresp = 2'b00;
      align();

      // reset while waiting in RD_R
      cfg_r_wait = 6;
      cfg_rdata = 32'h0BAD_F00D;
      req_we = 2'b00;
      req_addr[5:0] = 6'h08;
      req_valid = 2'b01;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (rready) break;
      end
      check("t6_in_rd_r", {63'b0, rready}, 64'd1);
      p0 = rsp_pulses;
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_rst_arvalid", {63'b0, arvalid}, 64'd0);
      check("t6_rst_rready", {63'b0, rready}, 64'd0);
      check("t6_rst_busy", {63'b0, busy}, 64'd0);
      check("t6_rst_req_ready", {62'b0, req_ready}, 64'd0);
      repeat (4) @(negedge clk);
      check("t6_rst_rsp_valid", {62'b0, rsp_valid}, 64'd0);
      check("t6_no_pulse", 64'(rsp_pulses - p0), 64'd0);
      cfg_r_wait = 0;
      sb.delete();
      align();
      rst_n = 1'b1;
      run(1, 2'b00, 3, 20);

      check("rw_overlap", 64'(rw_overlap), 64'd0);
      check("total_rsp_pulses", 64'(rsp_pulses), 64'd10);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/tis_axil_rw_arbiter.md
Name: tis_axil_rw_arbiter

Overview:
- Two-requester arbiter/sequencer that shares the single AXI4-Lite slave port of the tis100 register block (tis100_v1_0_S00_AXI).
- Typical requesters: a program loader (req 0) and a host/debug bridge (req 1).
- Each requester issues simple single-beat read or write commands; the block serialises them into one AXI4-Lite transaction at a time and returns the response to the originator.
- Sits between the requesters and the S00_AXI slave, acting as the AXI4-Lite master.

Parameters:
- C_M_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
- C_M_AXI_ADDR_WIDTH, 6, AXI byte address width; matches the tis100 register map.

Ports:
- M_AXI_ACLK  in  1  single clock; all logic on the rising edge.
- M_AXI_ARESETN  in  1  asynchronous, active-low reset.
- req_valid  in  2  bit i = requester i has a command pending; held until req_ready[i].
- req_ready  out  2  bit i = command i accepted this cycle (one-hot or zero).
- req_we  in  2  bit i: 1 = write, 0 = read.
- req_addr  in  2*AW  requester i address at bits [i*AW +: AW].
- req_wdata  in  2*DW  requester i write data at bits [i*DW +: DW].
- rsp_valid  out  2  one-cycle pulse to the originating requester when its transaction completes.
- rsp_rdata  out  DW  read data (write completion: 0); valid when any rsp_valid bit is set.
- rsp_resp  out  2  BRESP/RRESP copied from the slave.
- busy  out  1  high from command acceptance until the response pulse.
- M_AXI_AWADDR/AWVALID/AWREADY, M_AXI_WDATA/WSTRB/WVALID/WREADY, M_AXI_BRESP/BVALID/BREADY  std AXI4-Lite write channels (master side).
- M_AXI_ARADDR/ARVALID/ARREADY, M_AXI_RDATA/RRESP/RVALID/RREADY  std AXI4-Lite read channels (master side).
- M_AXI_AWPROT, M_AXI_ARPROT  out  3 each  constant 3'b000; M_AXI_WSTRB constant 4'b1111.

Behaviour:
- FSM states: IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP.
- IDLE:
  - Pick a winner among set req_valid bits.
  - Assert req_ready[winner] combinationally the same cycle.
  - Capture addr/wdata/we/id at that edge.
  - Go to WR_AW_W if we=1, else RD_AR.
- Round-robin grant: when both are valid, grant the requester not served last. last_grant resets to 1, so requester 0 wins the first tie.
- WR_AW_W:
  - AWVALID and WVALID both rise the cycle after acceptance.
  - Each drops independently on its own handshake (aw_done/w_done flags), in either order or the same cycle.
  - When both are done, go to WR_B.
  - AWADDR/WDATA stay stable while their VALID is high.
- WR_B: BREADY=1; on BVALID latch BRESP, rdata=0, go to RSP.
- RD_AR: ARVALID=1 until ARREADY, then go to RD_R.
- RD_R: RREADY=1; on RVALID latch RDATA/RRESP, go to RSP.
- RSP:
  - rsp_valid[id] high for exactly one cycle with the latched rdata/resp.
  - Update last_grant and return to IDLE.
  - No backpressure on the response.
- Latency with a zero-wait slave:
  - Write: accept at cycle 0, AW+W cycle 1, B cycle 2, rsp pulse cycle 3.
  - Read: accept at cycle 0, AR cycle 1, R cycle 2, rsp pulse cycle 3.
- The earliest next acceptance is the cycle after RSP (back-to-back spacing is 4 cycles).
- req_ready is never asserted outside IDLE. Requests arriving mid-transaction wait, and requester i's req_valid must stay high until req_ready[i].
- Only one transaction is outstanding at a time; read and write channels are never active together.
- Reset (asynchronous, any state, including mid-handshake):
  - Outputs go to 0: all VALID/READY, req_ready, rsp_valid, busy, AWADDR/ARADDR/WDATA, rsp_rdata, rsp_resp.
  - FSM goes to IDLE and last_grant to 1.
  - The in-flight transaction is dropped with no response pulse.
- SLVERR/DECERR from the slave is passed through on rsp_resp; there is no retry.

Optional Feature:
- Macro: TIS_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; requester 0 always wins when both are valid, and last_grant is unused.
- Undefined (default): round-robin as described above.

Test Plan:
- Reset asserted for 23 ns with req_valid=2'b01 held -> no AXI VALID and req_ready=0 during reset. After release: accept at cycle 0, AW/W with addr=0, data=5 at cycle 1, rsp_valid=2'b01 and rsp_resp=0 at cycle 3.
- Req 1 reads addr 6'h04 while the slave returns 32'hDEAD_BEEF after 3 wait cycles on ARREADY and 2 on RVALID -> ARVALID/RREADY held, then rsp_valid=2'b10 and rsp_rdata=32'hDEADBEEF.
- Both requesters valid continuously for 4 transactions -> grants in order 0,1,0,1. With TIS_ARB_FIXED_PRIO_EN defined -> grants 0,0,0,0.
- Slave asserts WREADY 2 cycles before AWREADY, then a second write with AWREADY first -> exactly one AW and one W handshake each, and BREADY only after both.
- Slave returns BRESP=2'b10 -> rsp_resp=2'b10 for one cycle, then the FSM returns to IDLE.
- Reset asserted while in RD_R -> ARVALID/RREADY go low immediately and no rsp_valid pulse. After release the pending request is re-accepted.
